// File: rtl/animated_sprite_bitmap_reader_if.sv
// Sprite ROM bus: the reader drives the registered address and the synchronous ROM
// returns the pixel byte one clock after it samples that address.
interface animated_sprite_bitmap_reader_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/animated_sprite_bitmap_reader.sv
// Fetches animated sprite pixels from an external synchronous ROM through a 3-stage pipeline,
// and produces a transparency-qualified draw request plus a pixel-accurate collision pulse and latch.
module animated_sprite_bitmap_reader #(
    parameter int            OBJECT_W    = 32,
    parameter int            OBJECT_H    = 32,
    parameter int            NUM_FRAMES  = 4,
    parameter int            FRAME_TICKS = 8,
    parameter logic [7:0]    TRANSPARENT = 8'hFF,
    localparam int           ADDR_W      = $clog2(NUM_FRAMES * OBJECT_W * OBJECT_H),
    localparam int           FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [10:0]          offsetX,
    input  logic [10:0]          offsetY,
    input  logic                 drawRequestIn,
    input  logic                 collisionIn,
    input  logic                 startOfFrame,
    input  logic                 animEnable,
    input  logic                 animRestart,
    animated_sprite_bitmap_reader_if.master rom,
    output logic [7:0]           RGBout,
    output logic                 drawingRequest,
    output logic                 collisionOut,
    output logic                 collisionLatched,
    output logic [FRAME_W-1:0]   frameIndex
);

    localparam int                TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [10:0]       W_LIMIT    = 11'(OBJECT_W);
    localparam logic [10:0]       H_LIMIT    = 11'(OBJECT_H);

    logic              in_bounds;
    logic [ADDR_W-1:0] pixel_addr;
    logic              valid_s1;
    logic              coll_s1;
    logic              valid_s2;
    logic              coll_s2;
    logic              opaque;
    logic              draw_next;
    logic              collision_next;
    logic [TICK_W-1:0] tick;

    // Bounds check uses the full 11-bit offsets so wide offsets never alias into the sprite.
    always_comb begin
        in_bounds  = (offsetX < W_LIMIT) && (offsetY < H_LIMIT);
        pixel_addr = ADDR_W'(frameIndex) * ADDR_W'(OBJECT_W * OBJECT_H)
                   + ADDR_W'(offsetY) * ADDR_W'(OBJECT_W)
                   + ADDR_W'(offsetX);
    end

    always_comb begin
        opaque         = (rom.rom_data != TRANSPARENT);
        draw_next      = valid_s2 && opaque;
        collision_next = coll_s2 && valid_s2 && opaque;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rom.rom_addr <= '0;
            valid_s1     <= 1'b0;
            coll_s1      <= 1'b0;
        end else begin
            rom.rom_addr <= in_bounds ? pixel_addr : '0;
            valid_s1     <= drawRequestIn && in_bounds;
            coll_s1      <= collisionIn && in_bounds;
        end
    end

    // The ROM registers the address on this same edge, so these flags line up with rom_data.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_s2 <= 1'b0;
            coll_s2  <= 1'b0;
        end else begin
            valid_s2 <= valid_s1;
            coll_s2  <= coll_s1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBout           <= 8'h00;
            drawingRequest   <= 1'b0;
            collisionOut     <= 1'b0;
            collisionLatched <= 1'b0;
        end else begin
            RGBout         <= rom.rom_data;
            drawingRequest <= draw_next;
            collisionOut   <= collision_next;
            // A collision arriving with startOfFrame belongs to the new frame, so set wins.
            if (collision_next) begin
                collisionLatched <= 1'b1;
            end else if (startOfFrame) begin
                collisionLatched <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tick       <= '0;
            frameIndex <= '0;
        end else if (animRestart) begin
            tick       <= '0;
            frameIndex <= '0;
        end else if (startOfFrame && animEnable) begin
            if (tick == TICK_LAST) begin
                tick       <= '0;
                frameIndex <= (frameIndex == FRAME_LAST) ? '0 : frameIndex + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

endmodule

// File: doc/animated_sprite_bitmap_reader.md
Name: animated_sprite_bitmap_reader

Overview:
- Sits directly downstream of the four-way offset/collision mux.
- Takes the muxed object-relative offset, draw request and collision flag, and fetches the pixel from an external synchronous sprite ROM. The ROM holds NUM_FRAMES animation frames.
- Outputs a registered RGB value plus a transparency-qualified drawing request for the VGA object mux.
- Also runs the animation frame counter and a pixel-accurate collision detector (pulse plus per-video-frame latch).

Parameters:
- OBJECT_W, 32, sprite width in pixels (power of 2).
- OBJECT_H, 32, sprite height in pixels (power of 2).
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM (power of 2).
- FRAME_TICKS, 8, startOfFrame pulses per animation step (≥1).
- TRANSPARENT, 8'hFF, ROM value meaning "do not draw".
- ADDR_W, derived localparam, clog2(NUM_FRAMES*OBJECT_W*OBJECT_H); 12 at defaults.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- offsetX  in  11  pixel X relative to sprite top-left
- offsetY  in  11  pixel Y relative to sprite top-left
- drawRequestIn  in  1  pixel lies inside the object rectangle
- collisionIn  in  1  rectangle-level collision from the mux
- startOfFrame  in  1  one-cycle pulse per video frame
- animEnable  in  1  animation advances while high
- animRestart  in  1  synchronous return to frame 0
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  8  ROM data, valid one clock after rom_addr is sampled
- RGBout  out  8  registered pixel colour
- drawingRequest  out  1  opaque, in-bounds, requested pixel
- collisionOut  out  1  pixel-accurate collision pulse
- collisionLatched  out  1  sticky collision flag for the current video frame
- frameIndex  out  clog2(NUM_FRAMES)  current animation frame

Behaviour:
- Reset (async, resetN low): all outputs 0, tick counter 0, pipeline valid bits 0.
- Reset mid-operation flushes the pipeline. No drawingRequest or collisionOut for 3 clocks after release.
- Pipeline, total latency 3 clocks from input sample to output:
  - S1, edge E1:
    - inb = offsetX < OBJECT_W && offsetY < OBJECT_H (unsigned compare).
    - rom_addr <= inb ? frameIndex*OBJECT_W*OBJECT_H + offsetY*OBJECT_W + offsetX : 0.
    - Registered v1 = drawRequestIn && inb; c1 = collisionIn && inb.
    - Address arithmetic is done at ADDR_W bits. Offsets are truncated only after the bounds check.
  - S2, edge E2: the ROM samples rom_addr. v2/c2 are delayed alongside.
  - S3, edge E3:
    - RGBout <= rom_data (unconditionally).
    - opaque = rom_data != TRANSPARENT.
    - drawingRequest <= v2 && opaque.
    - collisionOut <= c2 && v2 && opaque.
- Animation counter:
  - On startOfFrame && animEnable: tick increments.
  - When tick = FRAME_TICKS-1, tick wraps to 0 and frameIndex increments modulo NUM_FRAMES (wrap NUM_FRAMES-1 → 0).
  - animEnable low: tick and frameIndex hold.
  - animRestart clears tick and frameIndex the next edge. It has priority over startOfFrame in the same cycle.
  - frameIndex changes take effect at S1 of the next sampled pixel. The 3-stage pipeline is not re-aligned; mid-line changes only occur at startOfFrame (blanking), so there is no tearing.
- Collision latch:
  - Set by collisionOut's next-state value.
  - Cleared by startOfFrame.
  - If both occur in the same cycle, set wins (the collision belongs to the new frame).
- No backpressure. One pixel is accepted every clock.

Test Plan:
- Reset, then drawRequestIn=1, offset (3,2), frameIndex 0 → rom_addr=67 after E1; ROM model returns 8'h1C → RGBout=8'h1C, drawingRequest=1 exactly 3 clocks after input.
- Same pixel, ROM returns 8'hFF (TRANSPARENT) → drawingRequest=0, RGBout=8'hFF, collisionOut=0 even with collisionIn=1.
- Offset (32,0) and offset (0,40) with drawRequestIn=1 → rom_addr=0, drawingRequest=0, collisionOut=0.
- Animation, animEnable=1:
  - 8 startOfFrame pulses → frameIndex=1.
  - Then offset (0,0) → rom_addr=1024.
  - 32 total pulses → frameIndex=0.
  - animEnable=0 → 8 pulses leave frameIndex unchanged.
- collisionIn=1 on an opaque in-bounds pixel → collisionOut one-clock pulse at +3, collisionLatched=1; next startOfFrame clears it; a startOfFrame coinciding with a new collisionOut leaves it 1.
- frameIndex=2 with animRestart and startOfFrame in the same cycle → frameIndex=0, tick=0. Assert resetN low mid-stream → all outputs 0 immediately, no drawingRequest for 3 clocks after release.
